// File: rtl/cdc_word_tx_if.sv
// Handshake and crossing bus for cdc_word_tx: local valid/ready word input plus
// the held data bus, request flag and asynchronous acknowledge echo.
interface cdc_word_tx_if #(
   parameter int WIDTH = 8
) ();
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_flag;
   logic             ack_flag;

   // Transmitter (DUT) view
   modport slave (
      input  in_data,
      input  in_valid,
      input  ack_flag,
      output in_ready,
      output out_data,
      output out_flag
   );

   // Producer / remote-side view
   modport master (
      output in_data,
      output in_valid,
      output ack_flag,
      input  in_ready,
      input  out_data,
      input  out_flag
   );
endinterface

// File: rtl/cdc_word_tx.sv
// Toggle-flag clock-crossing transmitter: FIFO-buffered words, held data bus, flag toggle, ack echo wait.
// Optional ack timeout with sticky err is enabled by defining CDC_WORD_TX_TIMEOUT_EN.
module cdc_word_tx #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 4,
   parameter int DELAY   = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     reset_n,
   cdc_word_tx_if.slave             bus,
   output logic                     done,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   pending,
   output logic                     err,
   input  logic                     err_clear
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETUP    = 2'd1,
      ST_WAIT_ACK = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic [WIDTH-1:0] out_data_r;
   logic             out_flag_r;
   logic [DELAY-1:0] ack_sync_r;
   logic             ack_s;
   logic             ack_match_s;
   logic             in_ready_s;
   logic             push_s;
   logic             pop_s;
   logic             toggle_s;
   logic             done_s;
   logic             tmo_hit_s;

   assign in_ready_s  = (count_r != CW'(DEPTH));
   assign push_s      = bus.in_valid && in_ready_s;
   assign ack_s       = ack_sync_r[DELAY-1];
   assign ack_match_s = (ack_s == out_flag_r);

   // Ack echo synchronizer chain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ack_sync_r <= '0;
      end else begin
         ack_sync_r <= {ack_sync_r[DELAY-2:0], bus.ack_flag};
      end
   end

`ifdef CDC_WORD_TX_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] tmo_cnt_r;
   logic          err_r;

   // A matching ack on the final count still completes the word normally
   assign tmo_hit_s = (state_r == ST_WAIT_ACK) && !ack_match_s && (tmo_cnt_r == TMO_LAST);

   // WAIT_ACK dwell counter, cleared while entering from SETUP
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt_r <= '0;
      end else if (state_r == ST_SETUP) begin
         tmo_cnt_r <= '0;
      end else if (state_r == ST_WAIT_ACK) begin
         tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end
   end

   // Sticky timeout flag; a new timeout outranks a same-cycle clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_r <= 1'b0;
      end else if (tmo_hit_s) begin
         err_r <= 1'b1;
      end else if (err_clear) begin
         err_r <= 1'b0;
      end
   end

   assign err = err_r;
`else
   logic unused_err_clear_s;

   assign tmo_hit_s          = 1'b0;
   assign err                = 1'b0;
   assign unused_err_clear_s = err_clear;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state and per-state control strobes
   always_comb begin
      state_nxt_s = state_r;
      pop_s       = 1'b0;
      toggle_s    = 1'b0;
      done_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (count_r != CW'(0)) begin
               pop_s       = 1'b1;
               state_nxt_s = ST_SETUP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            toggle_s    = 1'b1;
            state_nxt_s = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (ack_match_s) begin
               done_s      = 1'b1;
               state_nxt_s = ST_IDLE;
            end else if (tmo_hit_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WAIT_ACK;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FIFO storage; contents are only read behind a non-zero count
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= bus.in_data;
      end
   end

   // FIFO pointers/count and the held crossing bus
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         out_data_r <= '0;
         out_flag_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r   <= rd_ptr_r + AW'(1);
            out_data_r <= mem_r[rd_ptr_r];
         end
         if (toggle_s) begin
            out_flag_r <= ~out_flag_r;
         end
         count_r <= count_r + CW'(push_s) - CW'(pop_s);
      end
   end

   assign bus.in_ready = in_ready_s;
   assign bus.out_data = out_data_r;
   assign bus.out_flag = out_flag_r;
   assign done         = done_s;
   assign busy         = (state_r != ST_IDLE);
   assign pending      = count_r + CW'(busy);

endmodule

// File: tb/tb_cdc_word_tx.sv
// Directed bench for cdc_word_tx: scoreboard of sent words checked on every out_flag toggle,
// plus cycle-exact latency, FIFO-full, spurious-ack, reset and (optional) timeout checks.
module tb_cdc_word_tx;
   localparam int WIDTH   = 8;
   localparam int DEPTH   = 4;
   localparam int DELAY   = 2;
   localparam int TIMEOUT = 16;

   logic                   clk = 1'b0;
   logic                   reset_n;
   logic                   done;
   logic                   busy;
   logic                   err;
   logic                   err_clear;
   logic [$clog2(DEPTH):0] pending;
   logic                   loop_en;
   logic                   ack_man;
   logic                   prev_flag;
   logic [WIDTH-1:0]       sb [$];
   int                     vectors     = 0;
   int                     miscompares = 0;
   int                     done_cnt    = 0;

   cdc_word_tx_if #(.WIDTH(WIDTH)) bus ();

   cdc_word_tx #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .DELAY  (DELAY),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus.slave),
      .done     (done),
      .busy     (busy),
      .pending  (pending),
      .err      (err),
      .err_clear(err_clear)
   );

   always #5 clk = ~clk;

   always_comb bus.ack_flag = loop_en ? bus.out_flag : ack_man;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic push_word(input logic [WIDTH-1:0] d, output bit acc);
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      acc          = bus.in_ready;
      if (acc) sb.push_back(d);
      step(1);
      bus.in_valid = 1'b0;
   endtask

   // Monitor: count done pulses, check each flagged word against the scoreboard
   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (reset_n !== 1'b1) begin
         prev_flag = bus.out_flag;
      end else if (bus.out_flag !== prev_flag) begin
         prev_flag = bus.out_flag;
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) chk("word", 32'(bus.out_data), 32'(sb.pop_front()));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      bit acc;
      int base;
      int acc_cnt;

      reset_n      = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      loop_en      = 1'b1;
      ack_man      = 1'b0;
      err_clear    = 1'b0;
      step(3);
      reset_n = 1'b1;
      step(1);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_busy",     32'(busy),         32'd0);
      chk("rst_pending",  32'(pending),      32'd0);
      chk("rst_out_flag", 32'(bus.out_flag), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'h00);
      chk("rst_err",      32'(err),          32'd0);
      base = done_cnt;
      step(20);
      chk("idle_no_done", 32'(done_cnt - base), 32'd0);

      // Single word with loopback: cycle-exact latency
      base = done_cnt;
      push_word(8'hA5, acc);
      chk("single_acc",     32'(acc),          32'd1);
      chk("single_pend0",   32'(pending),      32'd1);
      step(1);
      chk("single_data",    32'(bus.out_data), 32'hA5);
      chk("single_flag_n1", 32'(bus.out_flag), 32'd0);
      chk("single_busy",    32'(busy),         32'd1);
      step(1);
      chk("single_flag_n2", 32'(bus.out_flag), 32'd1);
      chk("single_done_n2", 32'(done),         32'd0);
      step(1);
      chk("single_done_n3", 32'(done),         32'd0);
      step(1);
      chk("single_done_n4", 32'(done),         32'd1);
      step(1);
      chk("single_done_n5", 32'(done),         32'd0);
      chk("single_idle",    32'(busy),         32'd0);
      chk("single_pend",    32'(pending),      32'd0);
      chk("single_ndone",   32'(done_cnt - base), 32'd1);

      // Ack toggling while idle must be ignored
      ack_man = bus.out_flag;
      loop_en = 1'b0;
      base    = done_cnt;
      ack_man = ~ack_man;
      step(6);
      chk("spur_busy_a", 32'(busy), 32'd0);
      ack_man = ~ack_man;
      step(6);
      chk("spur_busy_b", 32'(busy), 32'd0);
      chk("spur_no_done", 32'(done_cnt - base), 32'd0);
      loop_en = 1'b1;
      base    = done_cnt;
      push_word(8'h5C, acc);
      step(10);
      chk("spur_next_done", 32'(done_cnt - base), 32'd1);
      chk("spur_sb_empty",  32'(sb.size()),       32'd0);

      // Reset while waiting for an ack
      ack_man = bus.out_flag;
      loop_en = 1'b0;
      base    = done_cnt;
      push_word(8'h33, acc);
      step(3);
      chk("midrst_busy", 32'(busy),         32'd1);
      chk("midrst_flag", 32'(bus.out_flag), 32'd1);
      #1;
      reset_n = 1'b0;
      sb.delete();
      step(1);
      chk("midrst_flag0",  32'(bus.out_flag), 32'd0);
      chk("midrst_pend0",  32'(pending),      32'd0);
      chk("midrst_busy0",  32'(busy),         32'd0);
      chk("midrst_ready",  32'(bus.in_ready), 32'd1);
      chk("midrst_data0",  32'(bus.out_data), 32'h00);
      step(1);
      reset_n = 1'b1;
      ack_man = 1'b0;
      step(10);
      chk("midrst_no_done", 32'(done_cnt - base), 32'd0);
      chk("midrst_pend",    32'(pending),         32'd0);

      // Fill the FIFO with ack held, then drain via loopback
      ack_man = bus.out_flag;
      loop_en = 1'b0;
      base    = done_cnt;
      acc_cnt = 0;
      for (int i = 1; i <= 6; i++) begin
         bus.in_data  = 8'(i);
         bus.in_valid = 1'b1;
         if (bus.in_ready === 1'b1) begin
            sb.push_back(8'(i));
            acc_cnt++;
         end
         step(1);
      end
      bus.in_valid = 1'b0;
      chk("full_accepted", 32'(acc_cnt),      32'd5);
      chk("full_ready",    32'(bus.in_ready), 32'd0);
      chk("full_pending",  32'(pending),      32'd5);
      chk("full_inflight", 32'(bus.out_data), 32'h01);
      chk("full_no_done",  32'(done_cnt - base), 32'd0);
      loop_en = 1'b1;
      for (int c = 0; c < 300 && (done_cnt - base) < 5; c++) step(1);
      step(4);
      chk("drain_ndone", 32'(done_cnt - base), 32'd5);
      chk("drain_sb",    32'(sb.size()),       32'd0);
      chk("drain_flag",  32'(bus.out_flag),    32'd1);
      chk("drain_pend",  32'(pending),         32'd0);
      chk("drain_busy",  32'(busy),            32'd0);

`ifdef CDC_WORD_TX_TIMEOUT_EN
      // Stuck ack: abandon after TIMEOUT WAIT_ACK cycles
      ack_man = bus.out_flag;
      loop_en = 1'b0;
      base    = done_cnt;
      push_word(8'h77, acc);
      step(17);
      chk("tmo_err_pre",  32'(err),  32'd0);
      chk("tmo_busy_pre", 32'(busy), 32'd1);
      step(1);
      chk("tmo_err",      32'(err),     32'd1);
      chk("tmo_busy",     32'(busy),    32'd0);
      chk("tmo_pend",     32'(pending), 32'd0);
      step(3);
      chk("tmo_sticky",   32'(err),     32'd1);
      chk("tmo_no_done",  32'(done_cnt - base), 32'd0);
      err_clear = 1'b1;
      step(1);
      err_clear = 1'b0;
      chk("tmo_cleared",  32'(err), 32'd0);
      loop_en = 1'b1;
      step(1);
      base = done_cnt;
      push_word(8'h78, acc);
      step(10);
      chk("tmo_next_done", 32'(done_cnt - base), 32'd1);
      chk("tmo_next_err",  32'(err),             32'd0);
      chk("tmo_sb",        32'(sb.size()),       32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/cdc_word_tx.md
Name: cdc_word_tx

Overview:
- Transmitting end of the toggle-flag (polarity-change) clock-crossing protocol.
- Accepts words from the local clock domain through a valid/ready interface and buffers them in a small FIFO.
- Presents each word on a held data bus, then toggles out_flag to signal it.
- Waits for the remote receiver to echo the flag on ack_flag before sending the next word.
- Pairs with the existing flag-to-strobe receiver logic on the remote side.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, FIFO depth in words; power of two, minimum 2.
- DELAY, 2, number of synchronizer stages applied to ack_flag; minimum 2.
- TIMEOUT, 1024, cycles allowed in WAIT_ACK before abort; used only with the optional feature.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  word to send.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept; equals (count != DEPTH).
- out_data  out  WIDTH  word presented to the remote domain; held stable while a transfer is in flight.
- out_flag  out  1  request flag; toggles once per word.
- ack_flag  in  1  remote echo of out_flag; asynchronous to clk.
- done  out  1  one-cycle strobe when a word is acknowledged.
- busy  out  1  high whenever state != IDLE.
- pending  out  CLOG2(DEPTH)+1  FIFO count plus 1 if a word is in flight.
- err  out  1  sticky timeout flag (optional feature).
- err_clear  in  1  clears err (optional feature).

Behaviour:
- Reset (reset_n low, asynchronous): FIFO pointers and count = 0; out_data = 0; out_flag = 0; ack synchronizer = 0; state = IDLE; done = 0; err = 0. Outputs therefore read in_ready = 1, busy = 0, pending = 0.
- Reset mid-transfer discards the in-flight word and all FIFO contents. The remote receiver must be reset together with this block.
- Ack synchronizer: DELAY-stage shift register of ack_flag. ack_s is the last stage.
- Push: on an edge where in_valid && in_ready, write in_data at the write pointer and increment count.
  - in_ready is computed from count before the edge. When full, a simultaneous pop does not permit a push that cycle.
- Pointers wrap modulo DEPTH.
- State IDLE:
  - If count != 0: out_data <= FIFO head, pop (count decrements), go to SETUP.
  - A push and a pop on the same edge leave count unchanged.
- State SETUP (exactly 1 cycle): out_flag <= ~out_flag, go to WAIT_ACK. This guarantees out_data is stable for at least one cycle before the flag changes.
- State WAIT_ACK:
  - When ack_s == out_flag: done = 1 for one cycle, go to IDLE.
  - Back-to-back words therefore take at least 3 cycles plus the ack round trip.
- Latency: a word pushed at edge N appears on out_data at N+1 (if IDLE), out_flag toggles at N+2, and done fires DELAY cycles after ack_flag matches.
- Empty FIFO in IDLE: remain in IDLE; out_data and out_flag hold their last values.
- out_data changes only on the IDLE->SETUP transition.
- An ack_flag change while in IDLE or SETUP is ignored; no spurious done.

Optional Feature:
- Macro: CDC_WORD_TX_TIMEOUT_EN.
- With the macro defined:
  - A CLOG2(TIMEOUT)-bit counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle.
  - If it reaches TIMEOUT-1 without a matching ack: err <= 1 (sticky), the word is abandoned, state goes to IDLE, and no done is issued.
  - out_flag is not restored.
  - err_clear high for one cycle clears err. If timeout and err_clear coincide, the timeout wins and err stays 1.
- Without the macro: no counter; err is tied 0; err_clear is ignored; WAIT_ACK waits indefinitely.

Test Plan:
- Reset then idle: reset_n low 3 cycles, release -> in_ready=1, busy=0, pending=0, out_flag=0, out_data=0, done never pulses over 20 cycles.
- Single word, loopback (ack_flag=out_flag): push 0xA5 at edge N -> out_data=0xA5 at N+1, out_flag=1 at N+2, done pulse at N+2+DELAY, pending returns to 0.
- FIFO full: hold ack_flag=0 and push 6 words 0x01..0x06 -> 0x01 in flight, 0x02..0x05 buffered, in_ready=0, pending=5, 0x06 rejected. Release loopback -> out_data sequence 0x01..0x05 with out_flag toggling 1,0,1,0,1 and 5 done pulses.
- Spurious ack: toggle ack_flag while IDLE -> no done, state stays IDLE; next word still completes with exactly one done.
- Reset mid-transfer: push 0x33, ack held, assert reset_n low in WAIT_ACK -> out_flag=0, pending=0, no done after release.
- With CDC_WORD_TX_TIMEOUT_EN and TIMEOUT=16: push 0x77 with ack stuck -> err=1 after 16 WAIT_ACK cycles, busy=0, no done. Pulse err_clear -> err=0; next word with loopback completes.
